// File: rtl/fft_pkg.sv
// Shared widths, frame geometry and tone classes for the FFT peak tracker.
package fft_pkg;

  localparam int unsigned BIN_W     = 12;
  localparam int unsigned MAG_W     = 24;
  localparam int unsigned FRAME_LEN = 4096;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {NONE, LO, HI} tone_class_t;

endpackage

// File: rtl/bin_argmax.sv
// Per-frame bin scanner: checks beat sequencing and keeps the running argmax over
// the eligible bin window, publishing one result per well-formed frame.
module bin_argmax
  import fft_pkg::*;
#(
  parameter logic [BIN_W-1:0] MIN_BIN = 12'd1,
  parameter logic [BIN_W-1:0] MAX_BIN = 12'd1023
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [MAG_W-1:0] mag_i,
  input  logic [BIN_W-1:0] bin_i,
  input  logic             valid_i,
  input  logic             last_i,
  output logic             peak_valid_o,
  output logic [BIN_W-1:0] peak_bin_o,
  output logic [MAG_W-1:0] peak_mag_o,
  output logic             frame_err_o
);

  localparam logic [0:0] ST_WAIT_SOF = 1'b0;
  localparam logic [0:0] ST_SCAN     = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [BIN_W-1:0] exp_bin_q, exp_bin_d;
  logic [BIN_W-1:0] run_bin_q, run_bin_d;
  logic [MAG_W-1:0] run_mag_q, run_mag_d;
  logic             peak_valid_q, peak_valid_d;
  logic [BIN_W-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
  logic             frame_err_q, frame_err_d;

  logic             start, active, seq_err, end_err, in_range;
  logic [BIN_W-1:0] cur_bin, new_bin;
  logic [MAG_W-1:0] cur_mag, new_mag;

  always_comb begin
    start    = valid_i && (state_q == ST_WAIT_SOF) && (bin_i == '0);
    active   = start || (valid_i && (state_q == ST_SCAN));
    seq_err  = (state_q == ST_SCAN) && (bin_i != exp_bin_q);
    // tlast and the final bin index must coincide exactly
    end_err  = last_i != (bin_i == LAST_BIN);
    in_range = (bin_i >= MIN_BIN) && (bin_i <= MAX_BIN);
    cur_bin  = start ? '0 : run_bin_q;
    cur_mag  = start ? '0 : run_mag_q;
    if (in_range && (mag_i > cur_mag)) begin
      new_bin = bin_i;
      new_mag = mag_i;
    end else begin
      new_bin = cur_bin;
      new_mag = cur_mag;
    end

    state_d      = state_q;
    exp_bin_d    = exp_bin_q;
    run_bin_d    = run_bin_q;
    run_mag_d    = run_mag_q;
    peak_valid_d = 1'b0;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    frame_err_d  = 1'b0;

    if (active) begin
      if (seq_err || end_err) begin
        frame_err_d = 1'b1;
        state_d     = ST_WAIT_SOF;
      end else if (last_i) begin
        peak_valid_d = 1'b1;
        peak_bin_d   = new_bin;
        peak_mag_d   = new_mag;
        state_d      = ST_WAIT_SOF;
      end else begin
        state_d   = ST_SCAN;
        exp_bin_d = bin_i + BIN_W'(1);
        run_bin_d = new_bin;
        run_mag_d = new_mag;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_WAIT_SOF;
      exp_bin_q    <= '0;
      run_bin_q    <= '0;
      run_mag_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_bin_q    <= exp_bin_d;
      run_bin_q    <= run_bin_d;
      run_mag_q    <= run_mag_d;
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign peak_valid_o = peak_valid_q;
  assign peak_bin_o   = peak_bin_q;
  assign peak_mag_o   = peak_mag_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/mag_peak_tracker.sv
// FFT magnitude peak tracker: per-frame argmax plus a debounced hi/lo tone classifier
// that latches a tone after a run of agreeing frames and holds it for a fixed count.
module mag_peak_tracker
  import fft_pkg::*;
#(
  parameter logic [BIN_W-1:0] MIN_BIN        = 12'd1,
  parameter logic [BIN_W-1:0] MAX_BIN        = 12'd1023,
  parameter logic [MAG_W-1:0] MAG_THRESH     = 24'h000100,
  parameter logic [BIN_W-1:0] TONE_SPLIT     = 12'h030,
  parameter int unsigned      CONFIRM_FRAMES = 5,
  parameter int unsigned      HOLD_FRAMES    = 8
) (
  input  logic             clk_104mhz,
  input  logic             rst_n,
  input  logic [MAG_W-1:0] mag_tdata,
  input  logic [BIN_W-1:0] mag_tuser,
  input  logic             mag_tvalid,
  input  logic             mag_tlast,
  output logic             peak_valid,
  output logic [BIN_W-1:0] peak_bin,
  output logic [MAG_W-1:0] peak_mag,
  output logic             peak_found,
  output logic             frame_err,
  output logic             hi,
  output logic             lo
);

  localparam int unsigned RUN_W  = $clog2(CONFIRM_FRAMES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [0:0] ST_TRACK = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  bin_argmax #(
    .MIN_BIN(MIN_BIN),
    .MAX_BIN(MAX_BIN)
  ) u_bin_argmax (
    .clk_i       (clk_104mhz),
    .rst_ni      (rst_n),
    .mag_i       (mag_tdata),
    .bin_i       (mag_tuser),
    .valid_i     (mag_tvalid),
    .last_i      (mag_tlast),
    .peak_valid_o(peak_valid),
    .peak_bin_o  (peak_bin),
    .peak_mag_o  (peak_mag),
    .frame_err_o (frame_err)
  );

  assign peak_found = peak_mag > MAG_THRESH;

  logic [0:0]        cls_state_q, cls_state_d;
  tone_class_t       prev_q, prev_d;
  tone_class_t       tone_q, tone_d;
  logic [RUN_W-1:0]  run_q, run_d, run_next;
  logic [HOLD_W-1:0] hold_q, hold_d;
  tone_class_t       frame_cls;

  always_comb begin
    if (!peak_found || (peak_bin == TONE_SPLIT)) begin
      frame_cls = NONE;
    end else if (peak_bin > TONE_SPLIT) begin
      frame_cls = HI;
    end else begin
      frame_cls = LO;
    end

    cls_state_d = cls_state_q;
    prev_d      = prev_q;
    tone_d      = tone_q;
    run_d       = run_q;
    hold_d      = hold_q;
    run_next    = '0;

    if (peak_valid) begin
      unique case (cls_state_q)
        ST_TRACK: begin
          if (frame_cls == NONE) begin
            run_d = '0;
          end else begin
            run_next = (frame_cls == prev_q) ? run_q + RUN_W'(1) : RUN_W'(1);
            prev_d   = frame_cls;
            if (run_next == RUN_W'(CONFIRM_FRAMES)) begin
              cls_state_d = ST_HOLD;
              tone_d      = frame_cls;
              run_d       = '0;
              hold_d      = HOLD_W'(HOLD_FRAMES);
            end else begin
              run_d = run_next;
            end
          end
        end
        ST_HOLD: begin
          if (hold_q <= HOLD_W'(1)) begin
            cls_state_d = ST_TRACK;
            tone_d      = NONE;
            prev_d      = NONE;
            hold_d      = '0;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: cls_state_d = ST_TRACK;
      endcase
    end
  end

  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      cls_state_q <= ST_TRACK;
      prev_q      <= NONE;
      tone_q      <= NONE;
      run_q       <= '0;
      hold_q      <= '0;
    end else begin
      cls_state_q <= cls_state_d;
      prev_q      <= prev_d;
      tone_q      <= tone_d;
      run_q       <= run_d;
      hold_q      <= hold_d;
    end
  end

  assign hi = (cls_state_q == ST_HOLD) && (tone_q == HI);
  assign lo = (cls_state_q == ST_HOLD) && (tone_q == LO);

endmodule

// File: tb/tb_mag_peak_tracker.sv
// Directed bench for mag_peak_tracker: frame results are queued as they are sent and
// checked when the DUT publishes them; tone outputs are checked after every frame.
module tb_mag_peak_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] mag_tdata = '0;
  logic [11:0] mag_tuser = '0;
  logic        mag_tvalid = 1'b0;
  logic        mag_tlast = 1'b0;

  logic        peak_valid, peak_found, frame_err, hi, lo;
  logic [11:0] peak_bin;
  logic [23:0] peak_mag;

  logic        peak_valid_b, peak_found_b, frame_err_b, hi_b, lo_b;
  logic [11:0] peak_bin_b;
  logic [23:0] peak_mag_b;

  mag_peak_tracker u_dut (
    .clk_104mhz(clk),
    .rst_n     (rst_n),
    .mag_tdata (mag_tdata),
    .mag_tuser (mag_tuser),
    .mag_tvalid(mag_tvalid),
    .mag_tlast (mag_tlast),
    .peak_valid(peak_valid),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag),
    .peak_found(peak_found),
    .frame_err (frame_err),
    .hi        (hi),
    .lo        (lo)
  );

  // Short hold so expiry is observable within the run
  mag_peak_tracker #(
    .HOLD_FRAMES(2)
  ) u_dut_b (
    .clk_104mhz(clk),
    .rst_n     (rst_n),
    .mag_tdata (mag_tdata),
    .mag_tuser (mag_tuser),
    .mag_tvalid(mag_tvalid),
    .mag_tlast (mag_tlast),
    .peak_valid(peak_valid_b),
    .peak_bin  (peak_bin_b),
    .peak_mag  (peak_mag_b),
    .peak_found(peak_found_b),
    .frame_err (frame_err_b),
    .hi        (hi_b),
    .lo        (lo_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pv;
    logic        err;
    logic [11:0] bin;
    logic [23:0] mag;
    logic        found;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_exp, mon_obs;
  logic [23:0] fmag[4096];
  int          total = 0;
  int          bad = 0;
  logic [11:0] last_bin = '0;
  logic [23:0] last_mag = '0;
  logic        last_found = 1'b0;
  logic        exp_hi = 1'b0, exp_lo = 1'b0, exp_hib = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 4096; i++) fmag[i] = '0;
  endtask

  // Reference argmax over bins 1..1023, strict compare so ties keep the lower bin
  task automatic push_good();
    logic [11:0] bb;
    logic [23:0] bm;
    bb = '0;
    bm = '0;
    for (int i = 1; i <= 1023; i++) begin
      if (fmag[i] > bm) begin
        bb = 12'(i);
        bm = fmag[i];
      end
    end
    last_bin   = bb;
    last_mag   = bm;
    last_found = bm > 24'h000100;
    exp_q.push_back('{pv: 1'b1, err: 1'b0, bin: bb, mag: bm, found: last_found});
  endtask

  task automatic push_err();
    exp_q.push_back('{pv: 1'b0, err: 1'b1, bin: last_bin, mag: last_mag, found: last_found});
  endtask

  task automatic send_beats(input int from, input int to, input bit with_last);
    for (int i = from; i <= to; i++) begin
      @(posedge clk);
      #1;
      mag_tvalid = 1'b1;
      mag_tuser  = 12'(i);
      mag_tdata  = fmag[i];
      mag_tlast  = with_last && (i == to);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    mag_tvalid = 1'b0;
    mag_tlast  = 1'b0;
    mag_tuser  = '0;
    mag_tdata  = '0;
  endtask

  task automatic run_frame(input string tag, input logic nhi, input logic nlo, input logic nhib);
    push_good();
    send_beats(0, 4095, 1'b1);
    idle();
    // result pulse cycle: tone outputs must still show the previous state
    check({tag, "_tone_lat"}, 64'({hi, lo, hi_b}), 64'({exp_hi, exp_lo, exp_hib}));
    exp_hi  = nhi;
    exp_lo  = nlo;
    exp_hib = nhib;
    @(posedge clk);
    #1;
    check({tag, "_tone"}, 64'({hi, lo, hi_b}), 64'({exp_hi, exp_lo, exp_hib}));
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (peak_valid || frame_err)) begin
      total++;
      assert (exp_q.size() > 0)
      else begin
        bad++;
        $error("FAIL spurious_event observed pv=%0b err=%0b expected none", peak_valid,
               frame_err);
      end
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_obs = {peak_valid, frame_err, peak_bin, peak_mag, peak_found};
        total++;
        assert (mon_obs === mon_exp)
        else begin
          bad++;
          $error("FAIL frame_result observed=%0h expected=%0h", mon_obs, mon_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check("rst_outputs", 64'({peak_valid, frame_err, peak_bin, peak_mag, peak_found}), 64'd0);
    check("rst_tone", 64'({hi, lo, hi_b, lo_b}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    clear_frame(); fmag[100] = 24'h000800;
    run_frame("f1_single", 1'b0, 1'b0, 1'b0);

    clear_frame(); fmag[60] = 24'h000500; fmag[80] = 24'h000500;
    fmag[0] = 24'hFFFFFF; fmag[2000] = 24'hFFFFFF;
    run_frame("f2_tie", 1'b0, 1'b0, 1'b0);

    // Sequence break 10 -> 12 aborts the frame
    clear_frame(); fmag[5] = 24'h00F000;
    push_err();
    send_beats(0, 10, 1'b0);
    send_beats(12, 12, 1'b0);
    idle();
    @(posedge clk);
    #1;
    check("err_drain", 64'(exp_q.size()), 64'd0);
    check("err_tone", 64'({hi, lo}), 64'd0);

    clear_frame(); fmag[100] = 24'h000800;
    run_frame("f3_after_err", 1'b0, 1'b0, 1'b0);
    clear_frame(); fmag[200] = 24'h001234;
    run_frame("f4_hi", 1'b0, 1'b0, 1'b0);
    clear_frame(); fmag[20] = 24'h000900;
    run_frame("f5_lo_break", 1'b0, 1'b0, 1'b0);
    clear_frame(); fmag[1023] = 24'h000300; fmag[1024] = 24'hFFFFFF; fmag[1] = 24'h0002FF;
    run_frame("f6_max_edge", 1'b0, 1'b0, 1'b0);
    clear_frame(); fmag[60] = 24'h000500;
    run_frame("f7_hi", 1'b0, 1'b0, 1'b0);
    clear_frame(); fmag[100] = 24'h000800;
    run_frame("f8_hi", 1'b0, 1'b0, 1'b0);
    run_frame("f9_hi", 1'b0, 1'b0, 1'b0);
    run_frame("f10_confirm", 1'b1, 1'b0, 1'b1);

    clear_frame();
    run_frame("f11_empty", 1'b1, 1'b0, 1'b1);
    clear_frame(); fmag[48] = 24'h000900;
    run_frame("f12_split", 1'b1, 1'b0, 1'b0);
    clear_frame(); fmag[50] = 24'h000100;
    run_frame("f13_at_thresh", 1'b1, 1'b0, 1'b0);
    clear_frame(); fmag[1] = 24'h000101;
    run_frame("f14_min_edge", 1'b1, 1'b0, 1'b0);
    clear_frame(); fmag[500] = 24'h000400; fmag[4095] = 24'hFFFFFF;
    run_frame("f15_last_oor", 1'b1, 1'b0, 1'b0);
    clear_frame(); fmag[1023] = 24'h000300; fmag[1024] = 24'hFFFFFF;
    run_frame("f16_hold", 1'b1, 1'b0, 1'b0);
    clear_frame(); fmag[100] = 24'h000800;
    run_frame("f17_hold", 1'b1, 1'b0, 1'b0);

    // Reset while holding, at bin 2000 of a frame
    send_beats(0, 1999, 1'b0);
    @(posedge clk);
    #1;
    mag_tvalid = 1'b1;
    mag_tuser  = 12'd2000;
    mag_tdata  = '0;
    rst_n      = 1'b0;
    #1;
    check("midrst_tone", 64'({hi, lo, hi_b, lo_b}), 64'd0);
    check("midrst_outputs", 64'({peak_valid, frame_err, peak_bin, peak_mag, peak_found}),
          64'd0);
    exp_hi = 1'b0; exp_lo = 1'b0; exp_hib = 1'b0;
    last_bin = '0; last_mag = '0; last_found = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beats(2001, 4095, 1'b1);
    idle();
    @(posedge clk);
    #1;
    check("postrst_ignored", 64'(exp_q.size()), 64'd0);
    check("postrst_hold", 64'({peak_bin, peak_mag, peak_found, hi, lo}), 64'd0);

    clear_frame(); fmag[300] = 24'hABCDEF;
    run_frame("f19_restart", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
